// File: rtl/alu_pkg.sv
// Shared ALU definitions: default operand width and the subtract sequencer states.
package alu_pkg;

    localparam int ALU_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

endpackage

// File: rtl/sub_borrow_full.sv
// 1-bit full subtractor: out = A - B - bin, cout is the borrow into the next bit.
module sub_borrow_full (
    input  logic A,
    input  logic B,
    input  logic bin,
    output logic out,
    output logic cout
);

    assign out  = A ^ B ^ bin;
    assign cout = (~A & B) | (~(A ^ B) & bin);

endmodule

// File: rtl/serial_sub_seq.sv
// Bit-serial subtract sequencer: computes a - b LSB-first through one sub_borrow_full cell.
module serial_sub_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf,
    output logic             zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    sub_state_t       state;
    sub_state_t       state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             borrow_q;
    logic             a_msb;
    logic             b_msb;
    logic             cell_d;
    logic             cell_bout;
    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] diff_next;

    sub_borrow_full u_cell (
        .A    (a_sr[0]),
        .B    (b_sr[0]),
        .bin  (borrow_q),
        .out  (cell_d),
        .cout (cell_bout)
    );

    // A start is only honoured when no bits are in flight.
    assign accept    = start && (state != RUN);
    assign last_bit  = (state == RUN) && (cnt == LAST_BIT);
    assign diff_next = {cell_d, diff[WIDTH-1:1]};

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == LAST_BIT) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand shift registers, borrow feedback and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr     <= '0;
            b_sr     <= '0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            borrow_q <= 1'b0;
            cnt      <= '0;
        end else if (accept) begin
            a_sr     <= a;
            b_sr     <= b;
            a_msb    <= a[WIDTH-1];
            b_msb    <= b[WIDTH-1];
            borrow_q <= 1'b0;
            cnt      <= '0;
        end else if (state == RUN) begin
            a_sr     <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr     <= {1'b0, b_sr[WIDTH-1:1]};
            borrow_q <= cell_bout;
            if (!last_bit) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Result and flags; flags settle on the final bit and hold until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff       <= '0;
            borrow_out <= 1'b0;
            ovf        <= 1'b0;
            zero       <= 1'b0;
        end else if (accept) begin
            diff       <= '0;
            borrow_out <= 1'b0;
            ovf        <= 1'b0;
            zero       <= 1'b0;
        end else if (state == RUN) begin
            diff <= diff_next;
            if (last_bit) begin
                borrow_out <= cell_bout;
                ovf        <= (a_msb != b_msb) && (cell_d != a_msb);
                zero       <= (diff_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_serial_sub_seq.sv
// Self-checking bench for serial_sub_seq: directed cases plus random operands vs an arithmetic model.
module tb_serial_sub_seq;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             ovf;
    logic             zero;

    int n_cmp = 0;
    int n_bad = 0;

    serial_sub_seq #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .ovf        (ovf),
        .zero       (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic model(input logic [7:0] x, input logic [7:0] y,
                         output logic [7:0] d, output logic bo, output logic ov, output logic z);
        int sx, sy, r;
        d  = 8'((int'(x) - int'(y) + 256) % 256);
        bo = (x < y);
        sx = (x >= 8'h80) ? int'(x) - 256 : int'(x);
        sy = (y >= 8'h80) ? int'(y) - 256 : int'(y);
        r  = sx - sy;
        ov = (r < -128) || (r > 127);
        z  = (d == 8'h00);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [7:0] x, input logic [7:0] y);
        a = x;
        b = y;
        start = 1'b1;
        step();
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
    endtask

    // Called right after E0; returns edges counted from E0 inclusive.
    task automatic wait_done(output int edges, output int busy_cycles, output bit timed_out);
        edges = 1;
        busy_cycles = busy ? 1 : 0;
        timed_out = 1'b0;
        while (!done && edges < 40) begin
            step();
            edges++;
            if (busy) busy_cycles++;
        end
        if (!done) timed_out = 1'b1;
    endtask

    task automatic check_result(input string tag, input logic [7:0] x, input logic [7:0] y);
        logic [7:0] ed;
        logic ebo, eov, ez;
        model(x, y, ed, ebo, eov, ez);
        check({tag, ".diff"}, 32'(diff), 32'(ed));
        check({tag, ".borrow"}, 32'(borrow_out), 32'(ebo));
        check({tag, ".ovf"}, 32'(ovf), 32'(eov));
        check({tag, ".zero"}, 32'(zero), 32'(ez));
    endtask

    task automatic do_op(input string tag, input logic [7:0] x, input logic [7:0] y);
        int edges, bcyc;
        bit to;
        start_op(x, y);
        check({tag, ".busy_e0"}, 32'(busy), 32'd1);
        check({tag, ".clear_e0"}, 32'({diff, borrow_out, ovf, zero}), 32'd0);
        wait_done(edges, bcyc, to);
        check({tag, ".timeout"}, 32'(to), 32'd0);
        check({tag, ".latency"}, 32'(edges), 32'd9);
        check({tag, ".busy_cycles"}, 32'(bcyc), 32'd8);
        check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
        check_result(tag, x, y);
        step();
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
        check_result({tag, ".hold"}, x, y);
    endtask

    initial begin
        int edges, bcyc, ndone;
        bit to;
        logic [7:0] x, y, seen_diff;

        #12;
        check("reset.outputs", 32'({busy, done, diff, borrow_out, ovf, zero}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("idle.outputs", 32'({busy, done, diff, borrow_out, ovf, zero}), 32'd0);

        do_op("sub_05_03", 8'h05, 8'h03);
        do_op("sub_03_05", 8'h03, 8'h05);
        do_op("sub_80_01", 8'h80, 8'h01);
        do_op("sub_2A_2A", 8'h2A, 8'h2A);
        do_op("sub_7F_FF", 8'h7F, 8'hFF);

        // Start while busy must be ignored.
        start_op(8'h10, 8'h01);
        step();
        step();
        a = 8'hFF;
        b = 8'h00;
        start = 1'b1;
        step();
        start = 1'b0;
        ndone = 0;
        seen_diff = 8'h00;
        for (int i = 0; i < 14; i++) begin
            if (done) begin
                ndone++;
                seen_diff = diff;
            end
            step();
        end
        check("ignore.done_count", 32'(ndone), 32'd1);
        check("ignore.diff", 32'(seen_diff), 32'h0F);

        // Asynchronous reset part-way through an operation.
        start_op(8'h55, 8'h22);
        step();
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("abort.outputs", 32'({busy, done, diff, borrow_out, ovf, zero}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("abort.idle", 32'({busy, done}), 32'd0);
        do_op("after_abort", 8'h55, 8'h22);

        // Back-to-back start during the DONE cycle.
        start_op(8'hC3, 8'h3C);
        wait_done(edges, bcyc, to);
        check("b2b.first_timeout", 32'(to), 32'd0);
        check_result("b2b.first", 8'hC3, 8'h3C);
        a = 8'h01;
        b = 8'h02;
        start = 1'b1;
        step();
        start = 1'b0;
        check("b2b.done_drop", 32'(done), 32'd0);
        check("b2b.busy", 32'(busy), 32'd1);
        wait_done(edges, bcyc, to);
        check("b2b.timeout", 32'(to), 32'd0);
        check("b2b.latency", 32'(edges), 32'd9);
        check_result("b2b.second", 8'h01, 8'h02);
        step();

        for (int i = 0; i < 40; i++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            if (i % 8 == 0) y = x;
            do_op($sformatf("rand%0d", i), x, y);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
